// File: rtl/hazard_ctrl.sv
// Hazard and forwarding control for the 5-stage RV32I pipeline: shadow EX/MEM/WB
// tracking, forwarding selects, load-use stall, branch flush, memory-wait freeze.
module hazard_ctrl #(
    parameter int CNT_W  = 32,
    parameter int NREG_W = 5
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              id_valid,
    input  logic [NREG_W-1:0] id_rs1_addr,
    input  logic [NREG_W-1:0] id_rs2_addr,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [NREG_W-1:0] id_rd_addr,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              ex_flush,
    input  logic              mem_wait,
    output logic              pc_stall,
    output logic              if_id_stall,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic              ex_valid, ex_reg_write, ex_mem_read, ex_uses_rs1, ex_uses_rs2;
    logic [NREG_W-1:0] ex_rd, ex_rs1, ex_rs2;
    logic              mem_valid, mem_reg_write, mem_mem_read;
    logic [NREG_W-1:0] mem_rd;
    logic              wb_valid, wb_reg_write;
    logic [NREG_W-1:0] wb_rd;

    logic lu_raw;
    logic do_flush;
    logic do_stall;
    logic ex_take_bubble;

    // A load in EX whose rd (never x0) is read by the ID instruction.
    assign lu_raw = id_valid && ex_valid && ex_mem_read && (ex_rd != '0) &&
                    ((id_uses_rs1 && (id_rs1_addr == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2_addr == ex_rd)));

    assign do_flush       = ex_flush && !mem_wait;
    assign do_stall       = lu_raw && !ex_flush && !mem_wait;
    assign ex_take_bubble = ex_flush || lu_raw || !id_valid;

    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        if (mem_wait) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
        end else if (ex_flush) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (lu_raw) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            ex_valid      <= 1'b0;
            ex_rd         <= '0;
            ex_rs1        <= '0;
            ex_rs2        <= '0;
            ex_uses_rs1   <= 1'b0;
            ex_uses_rs2   <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            mem_valid     <= 1'b0;
            mem_rd        <= '0;
            mem_reg_write <= 1'b0;
            mem_mem_read  <= 1'b0;
            wb_valid      <= 1'b0;
            wb_rd         <= '0;
            wb_reg_write  <= 1'b0;
        end else if (!mem_wait) begin
            wb_valid      <= mem_valid;
            wb_rd         <= mem_rd;
            wb_reg_write  <= mem_reg_write;
            mem_valid     <= ex_valid;
            mem_rd        <= ex_rd;
            mem_reg_write <= ex_reg_write;
            mem_mem_read  <= ex_mem_read;
            if (ex_take_bubble) begin
                ex_valid     <= 1'b0;
                ex_rd        <= '0;
                ex_rs1       <= '0;
                ex_rs2       <= '0;
                ex_uses_rs1  <= 1'b0;
                ex_uses_rs2  <= 1'b0;
                ex_reg_write <= 1'b0;
                ex_mem_read  <= 1'b0;
            end else begin
                ex_valid     <= 1'b1;
                ex_rd        <= id_rd_addr;
                ex_rs1       <= id_rs1_addr;
                ex_rs2       <= id_rs2_addr;
                ex_uses_rs1  <= id_uses_rs1;
                ex_uses_rs2  <= id_uses_rs2;
                ex_reg_write <= id_reg_write;
                ex_mem_read  <= id_mem_read;
            end
        end
    end

    // Counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (do_stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (do_flush && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    // MEM wins over WB; a load in MEM is never a forward source.
    always_comb begin
        fwd_a_sel = 2'b00;
        if (ex_valid && ex_uses_rs1 && (ex_rs1 != '0)) begin
            if (mem_valid && mem_reg_write && (mem_rd == ex_rs1) && !mem_mem_read)
                fwd_a_sel = 2'b01;
            else if (wb_valid && wb_reg_write && (wb_rd == ex_rs1))
                fwd_a_sel = 2'b10;
        end
    end

    always_comb begin
        fwd_b_sel = 2'b00;
        if (ex_valid && ex_uses_rs2 && (ex_rs2 != '0)) begin
            if (mem_valid && mem_reg_write && (mem_rd == ex_rs2) && !mem_mem_read)
                fwd_b_sel = 2'b01;
            else if (wb_valid && wb_reg_write && (wb_rd == ex_rs2))
                fwd_b_sel = 2'b10;
        end
    end

    logic mem_load_hit;
    assign mem_load_hit = ex_valid && mem_valid && mem_mem_read &&
                          ((ex_uses_rs1 && (ex_rs1 != '0) && (mem_rd == ex_rs1)) ||
                           (ex_uses_rs2 && (ex_rs2 != '0) && (mem_rd == ex_rs2)));

    // The load-use stall must make a MEM-stage load dependency impossible.
    assert property (@(posedge clk) disable iff (!rst_) !mem_load_hit);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector testbench for hazard_ctrl; a CNT_W=4 copy shares the stimulus
// so counter saturation can be observed.
module tb_hazard_ctrl;

    localparam int NREG_W = 5;

    logic              clk = 1'b0;
    logic              rst_;
    logic              id_valid;
    logic [NREG_W-1:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic              id_uses_rs1, id_uses_rs2, id_reg_write, id_mem_read;
    logic              ex_flush, mem_wait;

    logic        pc_stall, if_id_stall, if_id_flush, id_ex_bubble;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [31:0] stall_cnt, flush_cnt;

    logic        pc_stall4, if_id_stall4, if_id_flush4, id_ex_bubble4;
    logic [1:0]  fwd_a_sel4, fwd_b_sel4;
    logic [3:0]  stall_cnt4, flush_cnt4;

    int tests = 0;
    int fails = 0;

    hazard_ctrl #(.CNT_W(32), .NREG_W(NREG_W)) dut (
        .clk(clk), .rst_(rst_), .id_valid(id_valid),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .ex_flush(ex_flush), .mem_wait(mem_wait),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_ctrl #(.CNT_W(4), .NREG_W(NREG_W)) dut4 (
        .clk(clk), .rst_(rst_), .id_valid(id_valid),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .ex_flush(ex_flush), .mem_wait(mem_wait),
        .pc_stall(pc_stall4), .if_id_stall(if_id_stall4), .if_id_flush(if_id_flush4),
        .id_ex_bubble(id_ex_bubble4), .fwd_a_sel(fwd_a_sel4), .fwd_b_sel(fwd_b_sel4),
        .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic u1, input logic u2, input logic [4:0] rd,
                                 input logic rw, input logic mr);
        id_valid     = v;
        id_rs1_addr  = rs1;
        id_rs2_addr  = rs2;
        id_uses_rs1  = u1;
        id_uses_rs2  = u2;
        id_rd_addr   = rd;
        id_reg_write = rw;
        id_mem_read  = mr;
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkCtrl(input string tag, input logic ps, input logic ifs,
                             input logic iff_, input logic bub);
        checkOutput({tag, ".pc_stall"}, 32'(pc_stall), 32'(ps));
        checkOutput({tag, ".if_id_stall"}, 32'(if_id_stall), 32'(ifs));
        checkOutput({tag, ".if_id_flush"}, 32'(if_id_flush), 32'(iff_));
        checkOutput({tag, ".id_ex_bubble"}, 32'(id_ex_bubble), 32'(bub));
    endtask

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_     = 1'b0;
        ex_flush = 1'b0;
        mem_wait = 1'b0;
        idle();

        // Reset with random inputs, then idle inputs for the check
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'($urandom), 5'($urandom), 5'($urandom), 1'($urandom),
                          1'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
            ex_flush = 1'($urandom);
            mem_wait = 1'($urandom);
            tick();
        end
        ex_flush = 1'b0;
        mem_wait = 1'b0;
        idle();
        tick();
        checkCtrl("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset.fwd_a", 32'(fwd_a_sel), 32'd0);
        checkOutput("reset.fwd_b", 32'(fwd_b_sel), 32'd0);
        checkOutput("reset.stall_cnt", stall_cnt, 32'd0);
        checkOutput("reset.flush_cnt", flush_cnt, 32'd0);
        rst_ = 1'b1;

        // ADD x3,x1,x2 ; ADD x4,x3,x1 -> MEM forward on A
        applyStimulus(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0); tick();
        applyStimulus(1, 5'd3, 5'd1, 1, 1, 5'd4, 1, 0);
        checkCtrl("alu_dep.id", 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); idle();
        checkOutput("alu_dep.fwd_a", 32'(fwd_a_sel), 32'd1);
        checkOutput("alu_dep.fwd_b", 32'(fwd_b_sel), 32'd0);
        tick();

        // ADD x8 ; unrelated ADD x10 ; ADD x11,x8,x2 -> WB forward on A
        applyStimulus(1, 5'd1, 5'd2, 1, 1, 5'd8, 1, 0); tick();
        applyStimulus(1, 5'd1, 5'd2, 1, 1, 5'd10, 1, 0); tick();
        applyStimulus(1, 5'd8, 5'd2, 1, 1, 5'd11, 1, 0); tick(); idle();
        checkOutput("wb_dep.fwd_a", 32'(fwd_a_sel), 32'd2);
        checkOutput("wb_dep.fwd_b", 32'(fwd_b_sel), 32'd0);

        // Two writers of x3 in MEM and WB -> MEM wins
        applyStimulus(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0); tick();
        applyStimulus(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0); tick();
        applyStimulus(1, 5'd3, 5'd3, 1, 1, 5'd12, 1, 0); tick(); idle();
        checkOutput("mem_wb.fwd_a", 32'(fwd_a_sel), 32'd1);
        checkOutput("mem_wb.fwd_b", 32'(fwd_b_sel), 32'd1);
        tick(); tick(); tick();

        // LW x5,8(x1) ; ADD x6,x5,x5 -> one stall cycle then WB forward
        applyStimulus(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1); tick();
        applyStimulus(1, 5'd5, 5'd5, 1, 1, 5'd6, 1, 0);
        checkCtrl("lu.stall", 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        checkCtrl("lu.after", 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("lu.stall_cnt", stall_cnt, 32'd1);
        tick(); idle();
        checkOutput("lu.fwd_a", 32'(fwd_a_sel), 32'd2);
        checkOutput("lu.fwd_b", 32'(fwd_b_sel), 32'd2);
        checkOutput("lu.stall_cnt2", stall_cnt, 32'd1);
        tick(); tick(); tick();

        // Taken branch while ID holds a load-use dependent instruction
        applyStimulus(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1); tick();
        applyStimulus(1, 5'd5, 5'd5, 1, 1, 5'd6, 1, 0);
        ex_flush = 1'b1; #1;
        checkCtrl("flush", 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        ex_flush = 1'b0; idle();
        checkOutput("flush.stall_cnt", stall_cnt, 32'd1);
        checkOutput("flush.flush_cnt", flush_cnt, 32'd1);
        checkOutput("flush.fwd_a", 32'(fwd_a_sel), 32'd0);
        checkCtrl("flush.after", 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); tick();

        // mem_wait for 3 cycles with flush and load-use both pending
        applyStimulus(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0); tick();
        applyStimulus(1, 5'd3, 5'd0, 1, 0, 5'd5, 1, 1); tick();
        applyStimulus(1, 5'd5, 5'd5, 1, 1, 5'd6, 1, 0);
        ex_flush = 1'b1;
        mem_wait = 1'b1; #1;
        checkCtrl("wait.0", 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("wait.0.fwd_a", 32'(fwd_a_sel), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            checkCtrl($sformatf("wait.%0d", i), 1'b1, 1'b1, 1'b0, 1'b0);
            checkOutput($sformatf("wait.%0d.fwd_a", i), 32'(fwd_a_sel), 32'd1);
            checkOutput($sformatf("wait.%0d.stall_cnt", i), stall_cnt, 32'd1);
            checkOutput($sformatf("wait.%0d.flush_cnt", i), flush_cnt, 32'd1);
        end
        mem_wait = 1'b0; #1;
        checkCtrl("wait.release", 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        ex_flush = 1'b0; idle();
        checkOutput("wait.release.flush_cnt", flush_cnt, 32'd2);
        checkOutput("wait.release.stall_cnt", stall_cnt, 32'd1);
        tick(); tick(); tick();

        // x0 is never a hazard or forward source
        applyStimulus(1, 5'd1, 5'd0, 1, 0, 5'd0, 1, 0); tick();
        applyStimulus(1, 5'd0, 5'd0, 1, 1, 5'd7, 1, 0);
        checkCtrl("x0.alu.id", 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); idle();
        checkOutput("x0.fwd_a", 32'(fwd_a_sel), 32'd0);
        checkOutput("x0.fwd_b", 32'(fwd_b_sel), 32'd0);
        applyStimulus(1, 5'd1, 5'd0, 1, 0, 5'd0, 1, 1); tick();
        applyStimulus(1, 5'd0, 5'd0, 1, 1, 5'd7, 1, 0);
        checkCtrl("x0.load", 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); idle(); tick(); tick();
        checkOutput("x0.stall_cnt", stall_cnt, 32'd1);

        // 16 more load-use events: 32-bit copy counts, 4-bit copy saturates
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1); tick();
            applyStimulus(1, 5'd5, 5'd5, 1, 1, 5'd6, 1, 0); tick(); tick();
            if (i == 12)
                checkOutput("sat.cnt4_pre", 32'(stall_cnt4), 32'd14);
        end
        idle();
        checkOutput("sat.cnt4", 32'(stall_cnt4), 32'd15);
        checkOutput("sat.cnt32", stall_cnt, 32'd17);
        checkOutput("sat.flush4", 32'(flush_cnt4), 32'd2);
        tick(); tick();

        // Reset asserted while a load-use stall is pending
        applyStimulus(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1); tick();
        applyStimulus(1, 5'd5, 5'd5, 1, 1, 5'd6, 1, 0);
        rst_ = 1'b0; #1;
        tick();
        rst_ = 1'b1; #1;
        checkCtrl("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("mid_reset.stall_cnt", stall_cnt, 32'd0);
        checkOutput("mid_reset.flush_cnt", flush_cnt, 32'd0);
        checkOutput("mid_reset.stall_cnt4", 32'(stall_cnt4), 32'd0);
        tick();
        checkOutput("mid_reset.no_count", stall_cnt, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline control unit for the 5-stage RV32I core. It keeps a shadow pipeline of destination/write/load info for the EX, MEM and WB stages. From that it drives the operand-forwarding selects for the EX stage, the 1-cycle load-use stall, the branch/jump flush of the front end, and the global freeze on data-memory wait. It also maintains saturating stall/flush performance counters.

Parameters:
CNT_W, 32, width of the performance counters stall_cnt and flush_cnt
NREG_W, 5, register address width

Ports:
clk  input  1  clock, rising edge
rst_  input  1  synchronous active-low reset
id_valid  input  1  ID stage holds a real instruction
id_rs1_addr  input  NREG_W  rs1 of ID instruction
id_rs2_addr  input  NREG_W  rs2 of ID instruction
id_uses_rs1  input  1  ID instruction reads rs1
id_uses_rs2  input  1  ID instruction reads rs2
id_rd_addr  input  NREG_W  rd of ID instruction
id_reg_write  input  1  ID instruction writes rd
id_mem_read  input  1  ID instruction is a load
ex_flush  input  1  EX resolved taken branch/JAL/JALR (EX_stage flush)
mem_wait  input  1  data memory not ready; freeze whole pipe
pc_stall  output  1  hold PC
if_id_stall  output  1  hold IF/ID register
if_id_flush  output  1  clear IF/ID valid
id_ex_bubble  output  1  load ID/EX with a bubble (valid=0)
fwd_a_sel  output  2  EX operand A source: 00 regfile, 01 MEM-stage ALU result, 10 WB write data
fwd_b_sel  output  2  EX operand B source, same encoding
stall_cnt  output  CNT_W  count of load-use stall cycles
flush_cnt  output  CNT_W  count of flush events

Behaviour:
- Shadow entry per stage S in {EX, MEM, WB}: valid, rd, reg_write, mem_read, plus rs1/rs2/uses_rs1/uses_rs2 for EX.
- Reset (rst_=0 at edge): all shadow valid=0, counters=0. Outputs are combinational from the shadow registers and inputs, so after reset: pc_stall=if_id_stall=if_id_flush=id_ex_bubble=0 and fwd_*_sel=00 (given ex_flush=mem_wait=0).
- Load-use hazard lu = id_valid & EX.valid & EX.mem_read & EX.rd!=0 & ((id_uses_rs1 & id_rs1_addr==EX.rd) | (id_uses_rs2 & id_rs2_addr==EX.rd)).
- Priority, highest first: mem_wait > ex_flush > lu.
- mem_wait=1: pc_stall=if_id_stall=1; if_id_flush=id_ex_bubble=0; shadow pipe holds; counters hold; ex_flush is ignored and must be re-presented by EX after the wait.
- ex_flush=1 (no wait): if_id_flush=1 and id_ex_bubble=1; pc_stall=if_id_stall=0 (PC loads pc_branch); lu is suppressed; flush_cnt+1.
- lu=1 (no wait, no flush): pc_stall=if_id_stall=1 and id_ex_bubble=1 for exactly one cycle; stall_cnt+1. Next cycle the load is in MEM, so lu is no longer true for the same pair.
- Shadow advance on each edge unless mem_wait: WB<=MEM; MEM<=EX; EX<=bubble if (ex_flush|lu|~id_valid), else the ID fields.
- Forwarding for each EX source X (rs1->A, rs2->B), only when EX.valid & uses_X & rsX!=0:
  - 01 if MEM.valid & MEM.reg_write & MEM.rd==rsX & ~MEM.mem_read;
  - else 10 if WB.valid & WB.reg_write & WB.rd==rsX;
  - else 00.
  - MEM beats WB when both match.
  - MEM.mem_read with a match must never occur (guaranteed by lu); an assertion flags it.
- x0 is never a hazard or forward source: rd==0 is ignored everywhere.
- Counters saturate at all-ones and do not wrap.
- Reset asserted mid-stall or mid-flush clears everything on that edge; there is no residual stall afterwards.

Test Plan:
- Reset: rst_=0 for 2 cycles with random inputs -> all outputs 0, fwd sel 00, counters 0.
- ADD x3,x1,x2 then ADD x4,x3,x1 -> second instr in EX: fwd_a_sel=01, fwd_b_sel=00. One unrelated instr between them -> fwd_a_sel=10. Both MEM and WB write x3 -> 01.
- LW x5,8(x1) followed by ADD x6,x5,x5 -> exactly 1 cycle with pc_stall=if_id_stall=id_ex_bubble=1, stall_cnt=1; then the ADD in EX shows fwd_a_sel=fwd_b_sel=10.
- BEQ taken (ex_flush=1) while ID holds a load-use dependent instr -> if_id_flush=id_ex_bubble=1, pc_stall=0, stall_cnt unchanged, flush_cnt=1; next cycle EX shadow is invalid, so fwd sel 00.
- mem_wait=1 for 3 cycles with ex_flush=1 and lu pending -> pc_stall=if_id_stall=1, no flush/bubble, counters frozen, fwd sel stable. After release the flush takes effect.
- Writes to x0 (ADDI x0,x1,5 then ADD x7,x0,x0) -> fwd sel 00, no stall. Preload stall_cnt to all-ones via CNT_W=4 and 16 load-use events -> stall_cnt holds at 15.
